led_seg_mux: RTL and testbench
==============================

LED_SEG_MUX -- requirements
Module: led_seg_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 100000: clk cycles each digit is driven, legal range >=2.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  1 = display driven, 0 = all digits dark.
REQ-006 SHALL have port load  input  1  1 = capture data/dp into shadow register this cycle.
REQ-007 SHALL have port data  input  4*DIGITS  hex nibbles, nibble i = digit i, digit 0 rightmost.
REQ-008 SHALL have port dp  input  DIGITS  decimal point request per digit, 1 = lit.
REQ-009 SHALL have port blank_lz  input  1  1 = leading-zero blanking on.
REQ-010 SHALL have port k  output  7  segment cathodes, active low, k[0]=seg a … k[6]=seg g.
REQ-011 SHALL have port dp_n  output  1  decimal point cathode, active low.
REQ-012 SHALL have port a  output  DIGITS  digit anodes, active low, one-hot-low when lit.

Function
REQ-013 SHALL keep a prescaler counting 0..CLK_DIV-1, wrapping to 0 after CLK_DIV-1.
REQ-014 SHALL advance digit index idx by 1 on each prescaler wrap; idx wraps DIGITS-1 -> 0.
REQ-015 SHALL keep prescaler and idx running regardless of enable and load.
REQ-016 SHALL latch data and dp into shadow registers on every rising edge with load=1; with load=0 shadow holds.
REQ-017 SHALL derive all outputs only from shadow registers, never directly from data/dp.
REQ-018 SHALL register k, dp_n and a: outputs reflect idx/shadow/enable/blank_lz from the previous cycle (1-cycle latency; load to visible output = 2 cycles).
REQ-019 SHALL decode nibbles to standard hex glyphs; e.g. 0 -> 1000000, 1 -> 1111001, 8 -> 0000000, F -> 0001110 (k[6:0]).
REQ-020 SHALL drive a[idx]=0 and all other anode bits 1 when the current digit is lit.
REQ-021 SHALL treat digit i (i>0) as blanked when blank_lz=1 and shadow nibbles i..DIGITS-1 are all zero; digit 0 is never blanked.
REQ-022 SHALL, for a blanked or disabled digit, drive a all ones, k=1111111, dp_n=1.
REQ-023 SHALL drive dp_n = ~shadow_dp[idx] when the digit is lit.
REQ-024 SHALL, when enable=0, drive a all ones, k all ones, dp_n=1 from the next cycle.
REQ-025 SHALL, when load and a prescaler wrap coincide, use the new shadow value together with the new idx in the following cycle's outputs.
REQ-026 SHALL never assert more than one anode bit low in any cycle, including across idx wrap.

Reset
REQ-027 SHALL, on a cycle with reset=1, set prescaler=0, idx=0, shadow data=0, shadow dp=0, a all ones, k=1111111, dp_n=1.
REQ-028 SHALL give reset priority over load and enable, including mid-digit; first lit output appears the cycle after reset deasserts, with enable=1, as digit 0 showing 0.
REQ-029 SHALL hold reset behaviour for as long as reset stays 1.

Verification (DIGITS=4, CLK_DIV=4)
REQ-030 SHALL cover: reset, enable=1, load data=16'h12AF, dp=0 -> after 2 cycles digit 0 shows k=0001110, a=1110; a advances every 4 cycles 1110,1101,1011,0111,1110.
REQ-031 SHALL cover: load data=16'h0005, blank_lz=1 -> only digit 0 lit (k=0010010); idx 1..3 slots give a=1111; with blank_lz=0 all show 1000000 except digit 0.
REQ-032 SHALL cover: data=16'h0000, blank_lz=1 -> digit 0 shows 0 (k=1000000), digits 1..3 dark.
REQ-033 SHALL cover: dp=4'b0100 -> dp_n=0 only while a=1011.
REQ-034 SHALL cover: enable dropped mid-digit -> a=1111, k=1111111 the next cycle; on re-enable, rotation phase continues unaltered.
REQ-035 SHALL cover: reset asserted during idx=2 -> next cycle all outputs dark, idx=0, shadow cleared; load changing data while load=0 -> outputs unchanged.

Source files
------------

// File: rtl/led_seg_mux.sv
// led_seg_mux: time-multiplexed hex seven-segment driver with shadow register,
// leading-zero blanking and registered active-low cathode/anode outputs.
module led_seg_mux #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [6:0]            k,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     a
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   blk;
    logic                z;
    logic [3:0]          nib;
    logic [6:0]          seg;
    logic                lit;
    logic                wrap;

    // blk[i] is set when nibbles i..DIGITS-1 are all zero; digit 0 never qualifies
    always_comb begin
        blk = '0;
        z   = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            z      = z & (sh_data[4*i +: 4] == 4'd0);
            blk[i] = z;
        end
        nib  = sh_data[idx*4 +: 4];
        lit  = enable & ~(blank_lz & blk[idx]);
        wrap = cnt == CW'(CLK_DIV - 1);
    end

    always_comb begin
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            sh_data <= '0;
            sh_dp   <= '0;
            k       <= '1;
            dp_n    <= 1'b1;
            a       <= '1;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
            if (load) begin
                sh_data <= data;
                sh_dp   <= dp;
            end
            k    <= lit ? seg : '1;
            dp_n <= ~(lit & sh_dp[idx]);
            a    <= lit ? ~(DIGITS'(1) << idx) : '1;
        end
    end
endmodule

// File: tb/tb_led_seg_mux.sv
// tb_led_seg_mux: scoreboard bench; a behavioural display model predicts each
// cycle's outputs into a queue, a negedge monitor pops and compares.
module tb_led_seg_mux;
    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  k;
    logic        dp_n;
    logic [3:0]  a;

    led_seg_mux #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .data(data),
        .dp(dp), .blank_lz(blank_lz), .k(k), .dp_n(dp_n), .a(a)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int unsigned   chk_cnt = 0;
    int unsigned   pass_cnt = 0;
    logic [11:0]   q [$];
    int            m_presc = 0;
    int            m_idx = 0;
    int unsigned   m_val = 0;
    bit [3:0]      m_dp = '0;

    // Reference: the displayed digit is nibble m_idx of the stored value, blanked
    // when blank_lz is on and the value has no non-zero nibble at or above m_idx.
    always @(posedge clk) begin
        if (reset) begin
            q.push_back(12'hFFF);
            m_presc = 0;
            m_idx   = 0;
            m_val   = 0;
            m_dp    = '0;
        end else begin
            bit          blank;
            int unsigned digit;
            blank = blank_lz && m_idx > 0 && (m_val >> (4 * m_idx)) == 0;
            digit = (m_val >> (4 * m_idx)) % 16;
            if (!enable || blank)
                q.push_back(12'hFFF);
            else
                q.push_back({glyph[digit], ~m_dp[m_idx], 4'(15 - (1 << m_idx))});
            m_presc = (m_presc + 1) % CLK_DIV;
            if (m_presc == 0)
                m_idx = (m_idx + 1) % DIGITS;
            if (load) begin
                m_val = 32'(data);
                m_dp  = dp;
            end
        end
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [11:0] exp;
            exp = q.pop_front();
            chk_cnt++;
            if ({k, dp_n, a} === exp)
                pass_cnt++;
            else
                $display("FAIL outputs t=%0t: got k=%b dp_n=%b a=%b, want k=%b dp_n=%b a=%b",
                         $time, k, dp_n, a, exp[11:5], exp[4], exp[3:0]);
            chk_cnt++;
            if ($countones(~a) <= 1)
                pass_cnt++;
            else
                $display("FAIL onehot t=%0t: got a=%b, want at most one low bit", $time, a);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_val(input logic [15:0] d, input logic [3:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        int budget;
        step(3);
        reset  = 1'b0;
        enable = 1'b1;
        step(2);
        load_val(16'h12AF, 4'b0000);
        step(20);
        blank_lz = 1'b1;
        load_val(16'h0005, 4'b0000);
        step(20);
        blank_lz = 1'b0;
        step(20);
        blank_lz = 1'b1;
        load_val(16'h0000, 4'b0000);
        step(20);
        blank_lz = 1'b0;
        load_val(16'h3456, 4'b0100);
        step(20);
        step(2);
        enable = 1'b0;
        step(5);
        enable = 1'b1;
        step(16);
        budget = 0;
        while (!(m_idx == 2 && m_presc == 1) && budget < 100) begin
            step(1);
            budget++;
        end
        chk_cnt++;
        if (budget < 100)
            pass_cnt++;
        else
            $display("FAIL idx2_wait: got no idx=2 slot in %0d cycles, want one within 100", budget);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data = 16'($urandom);
            dp   = 4'($urandom);
            step(1);
        end
        for (int i = 0; i < 2000; i++) begin
            enable   = $urandom_range(0, 9) != 0;
            load     = $urandom_range(0, 7) == 0;
            data     = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp       = 4'($urandom);
            reset    = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 49) == 0)
                blank_lz = ~blank_lz;
            step(1);
        end
        reset = 1'b0;
        load  = 1'b0;
        step(2);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
